axi_write_stager: RTL and testbench

//  Upstream feeder for the accelerator's AXI write master. Takes one write command (base

---
 rtl/axi_write_stager.sv | 140 ++++++++++++++
 tb/tb_axi_write_stager.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_write_stager.sv
// axi_write_stager: feeds the accelerator's AXI write master.
// It accepts one write command (byte base address and word count). It buffers the result
// words from the compute datapath in a staging FIFO. It then issues one core write request
// and streams the buffered words to the master's core data port. done pulses for one cycle
// after the last word has been handed off.
//
// Ports
//   clk, resetn               clock (rising edge) and asynchronous active-low reset
//   cmd_valid/ready/addr/words   command handshake; words may be 0
//   in_data/valid/ready       result word stream from compute
//   core_write_request_*      single write request (addr, len=words-1, size, INCR burst)
//   core_write_data*          data beats taken from the FIFO head
//   busy                      high whenever a command is in progress
//   done                      one-cycle pulse once every word has been handed off
module axi_write_stager #(
  parameter int unsigned AXI_AWIDTH = 32,
  parameter int unsigned AXI_DWIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [AXI_AWIDTH-1:0] cmd_addr,
  input  logic [31:0]           cmd_words,
  input  logic [AXI_DWIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  core_write_request_valid,
  input  logic                  core_write_request_ready,
  output logic [AXI_AWIDTH-1:0] core_write_addr,
  output logic [31:0]           core_write_len,
  output logic [2:0]            core_write_size,
  output logic [1:0]            core_write_burst,
  output logic [AXI_DWIDTH-1:0] core_write_data,
  output logic                  core_write_data_valid,
  input  logic                  core_write_data_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [2:0]  SizeVal = 3'($clog2(AXI_DWIDTH / 8));

  typedef enum logic [1:0] {StIdle, StReq, StData, StFin} state_e;

  state_e                state_q, state_d;
  logic [AXI_AWIDTH-1:0] addr_q, addr_d;
  logic [31:0]           len_q, len_d;
  logic [31:0]           in_left_q, in_left_d;
  logic [31:0]           out_left_q, out_left_d;
  logic [PW-1:0]         wptr_q, rptr_q;
  logic [AXI_DWIDTH-1:0] mem_q [FIFO_DEPTH];

  logic full, empty, push, pop;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty = (wptr_q == rptr_q);

  assign in_ready = ((state_q == StReq) || (state_q == StData)) && (in_left_q != '0) && !full;
  assign core_write_data_valid = (state_q == StData) && !empty;
  assign push = in_valid && in_ready;
  assign pop  = core_write_data_valid && core_write_data_ready;

  assign core_write_addr  = addr_q;
  assign core_write_len   = len_q;
  assign core_write_size  = SizeVal;
  assign core_write_burst = 2'b01;
  // Straight from storage: no bypass, stable while the head is not popped.
  assign core_write_data  = mem_q[rptr_q[AW-1:0]];
  assign busy             = (state_q != StIdle);

  always_comb begin
    state_d                  = state_q;
    addr_d                   = addr_q;
    len_d                    = len_q;
    in_left_d                = in_left_q;
    out_left_d               = out_left_q;
    cmd_ready                = 1'b0;
    core_write_request_valid = 1'b0;
    done                     = 1'b0;

    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d     = cmd_addr;
          len_d      = cmd_words - 32'd1;
          in_left_d  = cmd_words;
          out_left_d = cmd_words;
          state_d    = (cmd_words == '0) ? StFin : StReq;
        end
      end
      StReq: begin
        core_write_request_valid = 1'b1;
        if (core_write_request_ready) state_d = StData;
      end
      StData: begin
        if (pop && (out_left_q == 32'd1)) state_d = StFin;
      end
      StFin: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // push/pop only occur in StReq/StData, so these never collide with the command latch.
    if (push) in_left_d  = in_left_q - 32'd1;
    if (pop)  out_left_d = out_left_q - 32'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      len_q      <= '0;
      in_left_q  <= '0;
      out_left_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      in_left_q  <= in_left_d;
      out_left_q <= out_left_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage needs no reset; the pointers define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= in_data;
  end

endmodule

// File: tb/tb_axi_write_stager.sv
module tb_axi_write_stager;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;

  logic          clk = 1'b0;
  logic          resetn;
  logic          cmd_valid, cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [31:0]   cmd_words;
  logic [DW-1:0] in_data;
  logic          in_valid, in_ready;
  logic          req_valid, req_ready;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_len;
  logic [2:0]    wr_size;
  logic [1:0]    wr_burst;
  logic [DW-1:0] wr_data;
  logic          wr_data_valid, wr_data_ready;
  logic          busy, done;

  axi_write_stager #(
    .AXI_AWIDTH(AW),
    .AXI_DWIDTH(DW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk                      (clk),
    .resetn                   (resetn),
    .cmd_valid                (cmd_valid),
    .cmd_ready                (cmd_ready),
    .cmd_addr                 (cmd_addr),
    .cmd_words                (cmd_words),
    .in_data                  (in_data),
    .in_valid                 (in_valid),
    .in_ready                 (in_ready),
    .core_write_request_valid (req_valid),
    .core_write_request_ready (req_ready),
    .core_write_addr          (wr_addr),
    .core_write_len           (wr_len),
    .core_write_size          (wr_size),
    .core_write_burst         (wr_burst),
    .core_write_data          (wr_data),
    .core_write_data_valid    (wr_data_valid),
    .core_write_data_ready    (wr_data_ready),
    .busy                     (busy),
    .done                     (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " cmd_ready"}, 64'(cmd_ready), 64'd1);
    chk({tag, " in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, " req_valid"}, 64'(req_valid), 64'd0);
    chk({tag, " data_valid"}, 64'(wr_data_valid), 64'd0);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " done"}, 64'(done), 64'd0);
    chk({tag, " addr"}, 64'(wr_addr), 64'd0);
    chk({tag, " len"}, 64'(wr_len), 64'd0);
    chk({tag, " size"}, 64'(wr_size), 64'd2);
    chk({tag, " burst"}, 64'(wr_burst), 64'd1);
  endtask

  task automatic idle_inputs();
    cmd_valid     = 1'b0;
    cmd_addr      = '0;
    cmd_words     = '0;
    in_valid      = 1'b0;
    in_data       = '0;
    req_ready     = 1'b0;
    wr_data_ready = 1'b0;
  endtask

  typedef struct {
    logic [31:0] addr;
    int          words;
    int          req_delay;      // cycles after cmd fire before request_ready rises
    int          in_pct;         // in_valid probability
    int          out_pct;        // data_ready probability
    int          hold_out_until; // data_ready forced low until this many words accepted
    int          reset_after;    // assert resetn after this many beats (0 = never)
    logic [31:0] exp_len;
  } vec_t;

  vec_t vecs[9];

  // The model is the spec's contract in terms of counts: words accepted, words emitted,
  // and whether the command / request have fired. Output data must equal the words offered,
  // in order.
  task automatic run_vec(input int id, input vec_t v);
    logic [DW-1:0] src[$];
    bit cmd_fired = 0, req_fired = 0, finished = 0;
    int accepted = 0, popped = 0, since = 0, occ;
    bit exp_in_ready, exp_req_valid, exp_data_valid, exp_done;
    bit in_f, out_f, req_f, cmd_f;
    string t;
    t = $sformatf("v%0d", id);
    for (int i = 0; i < v.words + 3; i++) src.push_back($urandom);

    @(negedge clk);
    for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
      cmd_valid     = !cmd_fired;
      cmd_addr      = cmd_fired ? $urandom : v.addr;
      cmd_words     = cmd_fired ? $urandom : 32'(v.words);
      in_valid      = ($urandom_range(99) < 32'(v.in_pct));
      in_data       = (accepted < src.size()) ? src[accepted] : $urandom;
      req_ready     = (since >= v.req_delay);
      wr_data_ready = (accepted >= v.hold_out_until) && ($urandom_range(99) < 32'(v.out_pct));
      #1;
      occ            = accepted - popped;
      exp_in_ready   = cmd_fired && (accepted < v.words) && (occ < int'(DEPTH));
      exp_req_valid  = cmd_fired && (v.words > 0) && !req_fired;
      exp_data_valid = req_fired && (occ > 0);
      exp_done       = cmd_fired && (popped == v.words);

      chk({t, " cmd_ready"}, 64'(cmd_ready), 64'(!cmd_fired));
      chk({t, " busy"}, 64'(busy), 64'(cmd_fired));
      chk({t, " in_ready"}, 64'(in_ready), 64'(exp_in_ready));
      chk({t, " req_valid"}, 64'(req_valid), 64'(exp_req_valid));
      chk({t, " data_valid"}, 64'(wr_data_valid), 64'(exp_data_valid));
      chk({t, " done"}, 64'(done), 64'(exp_done));
      if (exp_req_valid) begin
        chk({t, " req_addr"}, 64'(wr_addr), 64'(v.addr));
        chk({t, " req_len"}, 64'(wr_len), 64'(v.exp_len));
        chk({t, " req_size"}, 64'(wr_size), 64'd2);
        chk({t, " req_burst"}, 64'(wr_burst), 64'd1);
      end
      if (exp_data_valid && wr_data_valid) chk({t, " data"}, 64'(wr_data), 64'(src[popped]));

      cmd_f = cmd_valid && cmd_ready;
      in_f  = in_valid && in_ready;
      out_f = wr_data_valid && wr_data_ready;
      req_f = req_valid && req_ready;
      if (cmd_fired) since++;
      if (exp_done) finished = 1;
      cmd_fired = cmd_fired || cmd_f;
      req_fired = req_fired || req_f;
      accepted += int'(in_f);
      popped   += int'(out_f);

      if (v.reset_after > 0 && popped == v.reset_after) begin
        @(posedge clk);
        #2;
        idle_inputs();
        resetn = 1'b0;
        #1;
        check_reset_outputs({t, " midreset"});
        @(negedge clk);
        resetn = 1'b1;
        return;
      end
      @(negedge clk);
    end

    if (!finished) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: accepted %0d emitted %0d required %0d", t, accepted, popped,
               v.words);
      idle_inputs();
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      return;
    end

    chk({t, " accepted"}, 64'(accepted), 64'(v.words));
    chk({t, " emitted"}, 64'(popped), 64'(v.words));
    // After the done cycle the block must be idle again with no second done pulse.
    idle_inputs();
    in_valid = 1'b1;
    #1;
    chk({t, " post busy"}, 64'(busy), 64'd0);
    chk({t, " post cmd_ready"}, 64'(cmd_ready), 64'd1);
    chk({t, " post done"}, 64'(done), 64'd0);
    chk({t, " post in_ready"}, 64'(in_ready), 64'd0);
    in_valid = 1'b0;
  endtask

  initial begin
    idle_inputs();
    resetn = 1'b0;
    #2;
    check_reset_outputs("por");
    cmd_valid = 1'b1;
    cmd_words = 32'd5;
    #1;
    check_reset_outputs("por_cmd");
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    #1;
    check_reset_outputs("released");

    //          addr          words dly in   out  hold rst  exp_len
    vecs[0] = '{32'h0000_1000, 4,   0,  100, 100, 0,   0,   32'd3};
    vecs[1] = '{32'h0000_2000, 40,  0,  100, 100, 16,  0,   32'd39};
    vecs[2] = '{32'h0000_3000, 5,   10, 100, 100, 0,   0,   32'd4};
    vecs[3] = '{32'h0000_4000, 0,   0,  100, 100, 0,   0,   32'hFFFF_FFFF};
    vecs[4] = '{32'h0000_5000, 100, 0,  50,  50,  0,   0,   32'd99};
    vecs[5] = '{32'h0000_6000, 20,  0,  100, 100, 0,   7,   32'd19};
    vecs[6] = '{32'h0000_7000, 3,   0,  100, 100, 0,   0,   32'd2};
    vecs[7] = '{32'h0000_8004, 64,  3,  70,  30,  0,   0,   32'd63};
    vecs[8] = '{32'hFFFF_FFF0, 1,   2,  40,  60,  0,   0,   32'd0};

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Hand-written: a zero-word command must pulse done exactly one cycle after acceptance.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_words = 32'd0;
    cmd_addr  = 32'hABCD_0000;
    #1;
    chk("zero cmd_ready", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    idle_inputs();
    in_valid = 1'b1;
    #1;
    chk("zero done", 64'(done), 64'd1);
    chk("zero in_ready", 64'(in_ready), 64'd0);
    chk("zero req_valid", 64'(req_valid), 64'd0);
    @(negedge clk);
    #1;
    chk("zero done after", 64'(done), 64'd0);
    chk("zero busy after", 64'(busy), 64'd0);
    in_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
